// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for a small LC-3 style core: fetches one
// instruction word, decodes ADD/AND/NOT/BR, drives register-file controls.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] bus,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        DR,
  output logic        SR1,
  output logic        LDREG,
  output logic [2:0]  IR_slice_119,
  output logic [2:0]  IR_slice_86,
  output logic [2:0]  SR2,
  output logic [1:0]  ALUK,
  output logic        SR2MUX,
  output logic [15:0] imm5_sext,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [2:0]  nzp,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [2:0]  r_nzp;
  logic        r_illegal;
  logic        r_memRd;
  logic [15:0] r_memAddr;

  logic        w_fetchAddr;
  logic        w_irLoad;
  logic        w_setIllegal;
  logic        w_clrIllegal;
  logic        w_nzpLoad;
  logic        w_brLoad;
  logic        w_ldreg;

  logic [3:0]  w_opcode;
  logic        w_isAlu;
  logic        w_isBr;
  logic [15:0] w_brOffset;
  logic [2:0]  w_busNzp;

  assign w_opcode   = r_ir[15:12];
  assign w_isAlu    = (w_opcode == 4'b0001) || (w_opcode == 4'b0101) || (w_opcode == 4'b1001);
  assign w_isBr     = (w_opcode == 4'b0000);
  assign w_brOffset = {{7{r_ir[8]}}, r_ir[8:0]};
  assign w_busNzp   = bus[15] ? 3'b100 : ((bus == 16'h0000) ? 3'b010 : 3'b001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HALTED;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_fetchAddr  = 1'b0;
    w_irLoad     = 1'b0;
    w_setIllegal = 1'b0;
    w_clrIllegal = 1'b0;
    w_nzpLoad    = 1'b0;
    w_brLoad     = 1'b0;
    w_ldreg      = 1'b0;
    case (r_state)
      S_HALTED: begin
        if (run) begin
          w_stateNext  = S_FETCH1;
          w_clrIllegal = 1'b1;
        end
      end
      S_FETCH1: begin
        w_fetchAddr = 1'b1;
        w_stateNext = S_FETCH2;
      end
      S_FETCH2: begin
        if (mem_ready) begin
          w_irLoad    = 1'b1;
          w_stateNext = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_isAlu || w_isBr) begin
          w_stateNext = S_EXEC;
        end else begin
          w_setIllegal = 1'b1;
          w_stateNext  = S_HALTED;
        end
      end
      S_EXEC: begin
        w_stateNext = S_FETCH1;
        if (w_isAlu) begin
          w_ldreg   = 1'b1;
          w_nzpLoad = 1'b1;
        end else if (w_isBr && ((r_ir[11:9] & r_nzp) != 3'b000)) begin
          w_brLoad = 1'b1;
        end
      end
      default: begin
        w_stateNext = S_HALTED;
      end
    endcase
  end

  // Branch target is relative to the already-incremented pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= 16'h0000;
      r_ir      <= 16'h0000;
      r_nzp     <= 3'b010;
      r_illegal <= 1'b0;
      r_memRd   <= 1'b0;
      r_memAddr <= 16'h0000;
    end else begin
      if (w_fetchAddr) begin
        r_memAddr <= r_pc;
        r_memRd   <= 1'b1;
        r_pc      <= r_pc + 16'd1;
      end
      if (w_irLoad) begin
        r_ir    <= mem_rdata;
        r_memRd <= 1'b0;
      end
      if (w_brLoad) begin
        r_pc <= r_pc + w_brOffset;
      end
      if (w_nzpLoad) begin
        r_nzp <= w_busNzp;
      end
      if (w_setIllegal) begin
        r_illegal <= 1'b1;
      end else if (w_clrIllegal) begin
        r_illegal <= 1'b0;
      end
    end
  end

  always_comb begin
    ALUK = 2'b11;
    case (w_opcode)
      4'b0001: ALUK = 2'b00;
      4'b0101: ALUK = 2'b01;
      4'b1001: ALUK = 2'b10;
      default: ALUK = 2'b11;
    endcase
  end

  assign mem_rd       = r_memRd;
  assign mem_addr     = r_memAddr;
  assign DR           = 1'b0;
  assign SR1          = 1'b1;
  assign LDREG        = w_ldreg;
  assign IR_slice_119 = r_ir[11:9];
  assign IR_slice_86  = r_ir[8:6];
  assign SR2          = r_ir[2:0];
  assign SR2MUX       = r_ir[5];
  assign imm5_sext    = {{11{r_ir[4]}}, r_ir[4:0]};
  assign pc           = r_pc;
  assign ir           = r_ir;
  assign nzp          = r_nzp;
  assign halted       = (r_state == S_HALTED);
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model compared every
// cycle, directed programs for the documented scenarios, then random programs.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] mem_rdata;
  logic        mem_ready = 1'b1;
  logic [15:0] bus = 16'h0000;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        DR, SR1, LDREG, SR2MUX, halted, illegal;
  logic [2:0]  IR_slice_119, IR_slice_86, SR2, nzp;
  logic [1:0]  ALUK;
  logic [15:0] imm5_sext, pc, ir;

  logic [15:0] memImage [65536];
  int          tests = 0;
  int          fails = 0;
  logic        ldSeen = 1'b0;

  assign mem_rdata = memImage[mem_addr];

  instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus(bus), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .DR(DR), .SR1(SR1), .LDREG(LDREG), .IR_slice_119(IR_slice_119),
    .IR_slice_86(IR_slice_86), .SR2(SR2), .ALUK(ALUK), .SR2MUX(SR2MUX),
    .imm5_sext(imm5_sext), .pc(pc), .ir(ir), .nzp(nzp), .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model: where the sequencer is within the current instruction.
  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_DECODE = 3, PH_EXEC = 4;
  int          mPhase;
  logic [15:0] mPc, mIr, mMemAddr;
  logic [2:0]  mNzp;
  logic        mMemRd, mIllegal;

  function automatic logic isAluOp(input logic [15:0] w);
    return w[15:12] inside {4'h1, 4'h5, 4'h9};
  endfunction

  function automatic logic isLegal(input logic [15:0] w);
    return isAluOp(w) || (w[15:12] == 4'h0);
  endfunction

  function automatic logic [2:0] flagsOf(input logic [15:0] b);
    if ($signed(b) < 0) return 3'b100;
    if (b == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int brOffset(input logic [15:0] w);
    int o;
    o = int'(w[8:0]);
    if (o >= 256) o = o - 512;
    return o;
  endfunction

  function automatic logic [15:0] sextImm5(input logic [15:0] w);
    int v;
    v = int'(w[4:0]);
    if (v >= 16) v = v - 32;
    return 16'(v);
  endfunction

  function automatic logic [1:0] aluCode(input logic [15:0] w);
    case (w[15:12])
      4'h1:    return 2'd0;
      4'h5:    return 2'd1;
      4'h9:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [15:0] randomInstr();
    logic [3:0] op;
    int r;
    r = $urandom_range(0, 15);
    case (r % 4)
      0:       op = 4'h1;
      1:       op = 4'h5;
      2:       op = 4'h9;
      default: op = 4'h0;
    endcase
    if (r >= 12) op = 4'($urandom);
    return {op, 12'($urandom)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPhase   <= PH_IDLE;
      mPc      <= 16'h0000;
      mIr      <= 16'h0000;
      mNzp     <= 3'b010;
      mIllegal <= 1'b0;
      mMemRd   <= 1'b0;
      mMemAddr <= 16'h0000;
    end else begin
      case (mPhase)
        PH_IDLE: if (run) begin
          mPhase   <= PH_ISSUE;
          mIllegal <= 1'b0;
        end
        PH_ISSUE: begin
          mMemAddr <= mPc;
          mMemRd   <= 1'b1;
          mPc      <= mPc + 16'd1;
          mPhase   <= PH_WAIT;
        end
        PH_WAIT: if (mem_ready) begin
          mIr    <= memImage[mMemAddr];
          mMemRd <= 1'b0;
          mPhase <= PH_DECODE;
        end
        PH_DECODE: if (isLegal(mIr)) mPhase <= PH_EXEC;
          else begin
            mIllegal <= 1'b1;
            mPhase   <= PH_IDLE;
          end
        PH_EXEC: begin
          if (isAluOp(mIr)) mNzp <= flagsOf(bus);
          else if ((mIr[11:9] & mNzp) != 3'b000) mPc <= 16'(int'(mPc) + brOffset(mIr));
          mPhase <= PH_ISSUE;
        end
        default: mPhase <= PH_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    if (!reset) begin
      checkOutput("pc", pc, mPc);
      checkOutput("ir", ir, mIr);
      checkOutput("mem_addr", mem_addr, mMemAddr);
      checkOutput("mem_rd", 16'(mem_rd), 16'(mMemRd));
      checkOutput("nzp", 16'(nzp), 16'(mNzp));
      checkOutput("illegal", 16'(illegal), 16'(mIllegal));
      checkOutput("halted", 16'(halted), 16'(mPhase == PH_IDLE));
      checkOutput("LDREG", 16'(LDREG), 16'(mPhase == PH_EXEC && isAluOp(mIr)));
      checkOutput("ALUK", 16'(ALUK), 16'(aluCode(mIr)));
      checkOutput("SR2", 16'(SR2), 16'(mIr[2:0]));
      checkOutput("IR_slice_119", 16'(IR_slice_119), 16'(mIr[11:9]));
      checkOutput("IR_slice_86", 16'(IR_slice_86), 16'(mIr[8:6]));
      checkOutput("SR2MUX", 16'(SR2MUX), 16'(mIr[5]));
      checkOutput("imm5_sext", imm5_sext, sextImm5(mIr));
      checkOutput("DR", 16'(DR), 16'h0000);
      checkOutput("SR1", 16'(SR1), 16'h0001);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ldSeen = ldSeen | LDREG;
    compareAll();
  endtask

  // Runs one zero-wait instruction starting from an observed FETCH1.
  task automatic applyStimulus(input logic [15:0] busVal);
    bus = busVal;
    ldSeen = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) memImage[a] = 16'h0000;
    memImage[16'h0000] = 16'h1283;
    memImage[16'h0001] = 16'h5283;
    memImage[16'h0002] = 16'h9283;
    memImage[16'h0010] = 16'h0405;
    memImage[16'h0011] = 16'hD000;
    memImage[16'h0013] = 16'h1283;
    memImage[16'h0016] = 16'h1283;
    memImage[16'h0017] = 16'h0FF8;

    #2 reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_ir", ir, 16'h0000);
    checkOutput("rst_nzp", 16'(nzp), 16'h0002);
    checkOutput("rst_illegal", 16'(illegal), 16'h0000);
    checkOutput("rst_mem_rd", 16'(mem_rd), 16'h0000);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_LDREG", 16'(LDREG), 16'h0000);
    checkOutput("rst_halted", 16'(halted), 16'h0001);
    reset = 1'b0;
    tick();

    run = 1'b1;
    bus = 16'h0001;
    tick();
    run = 1'b0;
    tick();
    checkOutput("add_mem_addr", mem_addr, 16'h0000);
    checkOutput("add_mem_rd", 16'(mem_rd), 16'h0001);
    checkOutput("add_pc", pc, 16'h0001);
    tick();
    checkOutput("add_ir", ir, 16'h1283);
    checkOutput("add_decode_LDREG", 16'(LDREG), 16'h0000);
    tick();
    checkOutput("add_exec_LDREG", 16'(LDREG), 16'h0001);
    checkOutput("add_SR2", 16'(SR2), 16'h0003);
    checkOutput("add_IR_slice_86", 16'(IR_slice_86), 16'h0002);
    checkOutput("add_ALUK", 16'(ALUK), 16'h0000);
    tick();
    checkOutput("add_nzp_pos", 16'(nzp), 16'h0001);
    checkOutput("add_after_LDREG", 16'(LDREG), 16'h0000);

    applyStimulus(16'h8000);
    checkOutput("and_nzp_neg", 16'(nzp), 16'h0004);
    applyStimulus(16'h0000);
    checkOutput("not_nzp_zero", 16'(nzp), 16'h0002);
    checkOutput("not_pc", pc, 16'h0003);
    repeat (13) applyStimulus(16'($urandom));
    checkOutput("nop_pc", pc, 16'h0010);
    checkOutput("nop_nzp", 16'(nzp), 16'h0002);

    applyStimulus(16'($urandom));
    checkOutput("brz_taken_pc", pc, 16'h0016);
    checkOutput("brz_taken_ld", 16'(ldSeen), 16'h0000);
    applyStimulus(16'h0001);
    checkOutput("add2_nzp", 16'(nzp), 16'h0001);
    checkOutput("add2_ld", 16'(ldSeen), 16'h0001);
    applyStimulus(16'($urandom));
    checkOutput("br_back_pc", pc, 16'h0010);
    applyStimulus(16'($urandom));
    checkOutput("brz_not_taken_pc", pc, 16'h0011);
    checkOutput("brz_not_taken_ld", 16'(ldSeen), 16'h0000);

    ldSeen = 1'b0;
    repeat (3) tick();
    checkOutput("ill_illegal", 16'(illegal), 16'h0001);
    checkOutput("ill_halted", 16'(halted), 16'h0001);
    checkOutput("ill_ld", 16'(ldSeen), 16'h0000);
    repeat (2) tick();
    run = 1'b1;
    tick();
    checkOutput("resume_illegal", 16'(illegal), 16'h0000);
    checkOutput("resume_halted", 16'(halted), 16'h0000);
    run = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checkOutput("wait_mem_rd", 16'(mem_rd), 16'h0001);
      checkOutput("wait_mem_addr", mem_addr, 16'h0012);
      checkOutput("wait_ir", ir, 16'hD000);
    end
    mem_ready = 1'b1;
    tick();
    checkOutput("wait_done_ir", ir, 16'h0000);
    repeat (2) tick();
    checkOutput("wait_next_pc", pc, 16'h0013);
    mem_ready = 1'b0;
    repeat (4) tick();
    checkOutput("rstmid_mem_rd_pre", 16'(mem_rd), 16'h0001);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_mem_rd", 16'(mem_rd), 16'h0000);
    checkOutput("rstmid_halted", 16'(halted), 16'h0001);
    checkOutput("rstmid_pc", pc, 16'h0000);
    tick();
    checkOutput("rstmid_ir", ir, 16'h0000);
    reset = 1'b0;

    memImage[16'h0000] = 16'h0FFE;
    memImage[16'hFFFF] = 16'h5283;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    applyStimulus(16'($urandom));
    checkOutput("wrap_pc_ffff", pc, 16'hFFFF);
    tick();
    checkOutput("wrap_mem_addr", mem_addr, 16'hFFFF);
    checkOutput("wrap_pc_0000", pc, 16'h0000);
    repeat (3) tick();

    for (int a = 0; a < 65536; a++) memImage[a] = randomInstr();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      run       = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      bus       = 16'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
